// File: rtl/btn_condition.sv
// Button conditioner: per-bit 2-flop synchronizer, debounce filter, and press/release/long-press
// strobes. All outputs are registered.
module btn_condition #(
    parameter int unsigned N_BTN           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned LONG_CYCLES     = 27000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] long_pulse
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] DbLast  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HoldMax = HW'(LONG_CYCLES);

    logic [N_BTN-1:0] sync1_q, sync2_q, s;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] press_q, press_d, release_q, release_d, long_q, long_d;
    logic [DW-1:0]    db_cnt_q [N_BTN];
    logic [DW-1:0]    db_cnt_d [N_BTN];
    logic [HW-1:0]    hold_q   [N_BTN];
    logic [HW-1:0]    hold_d   [N_BTN];

    always_comb begin
        s = ~sync2_q;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            stable_d[i] = stable_q[i];
            db_cnt_d[i] = '0;
            // Any sample agreeing with the stable level restarts the mismatch run.
            if (s[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    stable_d[i] = s[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
            press_d[i]   = stable_d[i] & ~stable_q[i];
            release_d[i] = ~stable_d[i] & stable_q[i];

            hold_d[i] = hold_q[i];
            if (!stable_d[i] || press_d[i]) begin
                hold_d[i] = '0;
            end else if (hold_q[i] != HoldMax) begin
                hold_d[i] = hold_q[i] + 1'b1;
            end
            // Saturation means the crossing into HoldMax happens once per press.
            long_d[i] = (hold_d[i] == HoldMax) && (hold_q[i] != HoldMax);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '1;
            sync2_q   <= '1;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= '0;
                hold_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= btn_n;
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                hold_q[i]   <= hold_d[i];
            end
        end
    end

    assign pressed       = stable_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;

endmodule

// File: doc/btn_condition.md
BTN_CONDITION -- requirements
Module: btn_condition

Interface
REQ-001 The block SHALL have parameter N_BTN, default 2, number of independent buttons.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 270000 (10 ms at 27 MHz), consecutive stable samples needed to accept a level change; legal range >= 1.
REQ-003 The block SHALL have parameter LONG_CYCLES, default 27000000 (1 s at 27 MHz), hold time after accepted press before long-press event; legal range >= 1.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 btn_n  input  N_BTN  raw asynchronous button pins, active-low (0 = pressed), bouncing.
REQ-007 pressed  output  N_BTN  debounced button level, active-high.
REQ-008 press_pulse  output  N_BTN  one-cycle strobe on accepted press.
REQ-009 release_pulse  output  N_BTN  one-cycle strobe on accepted release.
REQ-010 long_pulse  output  N_BTN  one-cycle strobe when a press has been held LONG_CYCLES.
REQ-011 All outputs SHALL be driven directly from registers; no combinational path from btn_n.

Function
REQ-012 Each btn_n bit SHALL pass through a 2-flop synchronizer; the second-stage output, inverted, is the sample s[i] (1 = pressed).
REQ-013 Each button SHALL have an independent debounce counter, width $clog2(DEBOUNCE_CYCLES+1), and stable-state register.
REQ-014 Per clock, per button: if s == stable, counter clears to 0; otherwise, if counter == DEBOUNCE_CYCLES-1, stable takes s and counter clears; otherwise counter increments.
REQ-015 Any single sample equal to stable during a mismatch run SHALL restart the run; no partial credit, no wrap.
REQ-016 pressed[i] SHALL equal the stable register.
REQ-017 press_pulse[i] SHALL be 1 for exactly the one cycle in which pressed[i] is 1 and was 0 the previous cycle; release_pulse[i] likewise for 1->0.
REQ-018 Latency: a clean btn_n edge SHALL produce the pressed change and pulse DEBOUNCE_CYCLES+2 rising edges after the first edge that samples the new level.
REQ-019 Each button SHALL have a hold counter, width $clog2(LONG_CYCLES+1), cleared while pressed is 0 and on press acceptance, incrementing each cycle while pressed is 1, saturating at LONG_CYCLES.
REQ-020 long_pulse[i] SHALL be 1 for exactly the one cycle in which the hold counter reaches LONG_CYCLES, i.e. LONG_CYCLES cycles after press_pulse; at most once per press.
REQ-021 Release before LONG_CYCLES SHALL produce no long_pulse; the hold counter clears on release acceptance.
REQ-022 Buttons SHALL be fully independent; simultaneous events on different bits SHALL all be reported in the same cycle.
REQ-023 press_pulse and release_pulse for the same bit SHALL never be 1 in the same cycle.

Reset
REQ-024 While rst_n is 0: synchronizer flops = released, all counters = 0, pressed = 0, all pulses = 0, immediately and asynchronously.
REQ-025 After rst_n deassert, a button held at reset SHALL be detected as a fresh press after DEBOUNCE_CYCLES+2 cycles, with press_pulse and subsequent long_pulse timing.
REQ-026 Reset asserted mid-debounce or mid-hold SHALL discard all partial counts; no pulse SHALL be emitted by reset or its release.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, N_BTN=2)
REQ-027 Reset: rst_n=0 with btn_n=2'b00 -> pressed=0 and all pulses 0 throughout reset; press_pulse=2'b11 on 6th edge after rst_n rises.
REQ-028 Clean press: btn_n[0] 1->0 and held -> press_pulse[0]=1 for one cycle 6 edges later, pressed[0]=1 thereafter, bit 1 unchanged.
REQ-029 Bounce: btn_n[0] low 3 cycles, high 1, low 3, high -> no pulse, pressed[0] stays 0; then low 4+ cycles -> single press_pulse.
REQ-030 Long press: hold btn_n[1]=0 -> long_pulse[1] exactly 10 cycles after press_pulse[1], once only over 50 held cycles; release -> release_pulse[1] 6 edges after, no long_pulse.
REQ-031 Short press: hold 8 cycles post-press_pulse then release -> release_pulse only, long_pulse never.
REQ-032 Reset mid-hold: pressed[0]=1, hold count 5, pulse rst_n low for 1 cycle while btn held -> outputs 0, press re-accepted 6 edges after release of reset, long_pulse 10 cycles after that.
